processador_multiciclo_param: RTL and testbench
===============================================

Name: processador_multiciclo_param

Overview:
Parametrised multicycle processor core and successor to the fixed 16-bit/8-register design. It has NREGS general registers plus internal registers A, G and IR, all DATA_W bits wide, and a single shared bus. The control counter walks T0..T3. The ALU is extended beyond add/sub with and, slt and sll, and illegal opcodes are trapped. The core is fed instruction and immediate words on DIN by the test harness or program-memory block.

Parameters:
DATA_W, 16, width of bus, registers and DIN; must satisfy DATA_W >= 3 + 2*RAW.
NREGS, 8, number of general registers; power of two, from 2 to 16.
RAW, $clog2(NREGS), register index width; derived, not overridden.

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Run  input  1  start request, sampled only in T0
DIN  input  DATA_W  instruction word in T0; immediate word in T1 of mvi
Done  output  1  high during the final step of an instruction (combinational from step/opcode)
BusWires  output  DATA_W  shared bus value

Behaviour:
- Instruction fields, taken from DIN/IR:
  - opcode = [DATA_W-1 -: 3]
  - X = next RAW bits below the opcode
  - Y = next RAW bits below X
  - remaining bits are ignored.
- Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-DIN; 010 add; 011 sub; 100 and; 101 slt; 110 sll; 111 illegal.
- Step counter Tstep is 2 bits.
  - Reset value T0.
  - Returns to T0 on the cycle after Done.
  - Otherwise increments each cycle while an instruction is active.
- T0: idle and fetch.
  - If Run=1: IR<=DIN, advance to T1.
  - Else stay in T0.
  - Bus drives 0.
- T1:
  - mv: bus=Ry, Rx<=bus, Done=1.
  - mvi: bus=DIN, Rx<=bus, Done=1.
  - ALU ops (010..110): bus=Rx, A<=bus.
  - illegal (111): bus=0, no register write, Done=1.
- T2 (ALU ops): bus=Ry, G<=ALU(A,bus).
- T3 (ALU ops): bus=G, Rx<=bus, Done=1.
- Latency: mv/mvi/illegal take 2 cycles including fetch; ALU ops take 4.
- Done is never high in T0.
- ALU rules:
  - add/sub are modulo 2^DATA_W, carry discarded.
  - and is bitwise.
  - slt: G=1 if A<bus as signed two's complement, else 0.
  - sll: G=A<<bus[$clog2(DATA_W)-1:0], zero-fill.
- X==Y is legal: operand values are latched in order, e.g. add R1,R1 doubles R1.
- Run while not in T0 is ignored; no queuing.
- Reset (any time, including mid-instruction):
  - Asynchronously clears R0..R(NREGS-1), A, G, IR to 0.
  - Tstep=T0, Done=0, BusWires=0.
  - No partial write completes.
- Exactly one bus source is selected per step; when none is selected the bus reads 0.

Optional Feature:
Macro PROC_STATUS_FLAGS_EN.
- Defined:
  - Adds output port Flags [1:0] = {N,Z}, reset 00.
  - Updated on the same edge that writes G (T2 of ALU ops).
  - Z = (result==0); N = result[DATA_W-1].
  - mv/mvi/illegal leave Flags unchanged.
- Undefined: no Flags port and no flag logic.

Test Plan:
Each line uses DATA_W=16, NREGS=8 and is stimulus -> required response.
1. mvi R0 via Run=1 DIN=0x2000, then DIN=0x0005 -> Done=1 in T1, BusWires=0x0005, R0=5.
2. mvi R1=3 (0x2400/0x0003), then add R0,R1 (0x4080) -> Done only in T3, BusWires=0x0008 in T3, R0=8; then sub R0,R1 (0x6080) -> R0=5.
3. mvi R2=0xFFFF (0x2800), mvi R3=1 (0x2C00), add R2,R3 (0x4980) -> R2=0x0000; with PROC_STATUS_FLAGS_EN, Flags=01.
4. slt with R4=0x8000, R5=0x0001, opcode 101 X=4 Y=5 (0xB280) -> R4=1; sll R5 by R3=1, opcode 110 X=5 Y=3 (0xD580) -> R5=2.
5. Illegal DIN=0xE000 -> Done=1 in T1, no register changes, back to T0 next cycle; Run held high during T1..T3 of an add -> no extra fetch.
6. Resetn pulsed low asynchronously mid-T2 of add -> Done=0 and BusWires=0 immediately, all registers 0, next Run fetches normally.

Source files
------------

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor: NREGS general registers, A/G/IR, one shared bus, T0..T3 control steps.
// Optional status flags output {N,Z} enabled with macro PROC_STATUS_FLAGS_EN.
module processador_multiciclo_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
`ifdef PROC_STATUS_FLAGS_EN
    output logic [1:0]        Flags,
`endif
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
);
    localparam int unsigned RAW  = $clog2(NREGS);
    localparam int unsigned IR_W = 3 + 2 * RAW;
    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
    typedef enum logic [2:0] {
        OP_MV  = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
        OP_AND = 3'b100, OP_SLT = 3'b101, OP_SLL = 3'b110, OP_ILL = 3'b111
    } opcode_e;

    tstep_e             tstep_q, tstep_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  g_q, g_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [DATA_W-1:0]  regs_d [NREGS];
    logic [DATA_W-1:0]  bus_c;
    logic [DATA_W-1:0]  alu_c;
    logic               done_c;
    logic               is_alu_c;
    opcode_e            op_c;
    logic [RAW-1:0]     rx_c, ry_c;
`ifdef PROC_STATUS_FLAGS_EN
    logic [1:0]         flags_q, flags_d;
`endif

    // Only the opcode/X/Y bits of the instruction are kept; the rest are ignored.
    assign op_c     = opcode_e'(ir_q[IR_W-1 -: 3]);
    assign rx_c     = ir_q[IR_W-4 -: RAW];
    assign ry_c     = ir_q[RAW-1:0];
    assign is_alu_c = (op_c != OP_MV) && (op_c != OP_MVI) && (op_c != OP_ILL);

    // ALU: A is the latched first operand, the bus carries the second.
    always_comb begin
        alu_c = '0;
        unique case (op_c)
            OP_ADD:  alu_c = a_q + bus_c;
            OP_SUB:  alu_c = a_q - bus_c;
            OP_AND:  alu_c = a_q & bus_c;
            OP_SLT:  alu_c = DATA_W'(($signed(a_q) < $signed(bus_c)) ? 1 : 0);
            OP_SLL:  alu_c = a_q << bus_c[SH_W-1:0];
            default: alu_c = '0;
        endcase
    end

    // Step sequencing, bus source selection and register write enables.
    always_comb begin
        tstep_d = tstep_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        regs_d  = regs_q;
        bus_c   = '0;
        done_c  = 1'b0;
`ifdef PROC_STATUS_FLAGS_EN
        flags_d = flags_q;
`endif
        unique case (tstep_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[DATA_W-1 -: IR_W];
                    tstep_d = T1;
                end
            end
            T1: begin
                if (op_c == OP_MV) begin
                    bus_c        = regs_q[ry_c];
                    regs_d[rx_c] = bus_c;
                    done_c       = 1'b1;
                end else if (op_c == OP_MVI) begin
                    bus_c        = DIN;
                    regs_d[rx_c] = bus_c;
                    done_c       = 1'b1;
                end else if (is_alu_c) begin
                    bus_c = regs_q[rx_c];
                    a_d   = bus_c;
                end else begin
                    done_c = 1'b1;
                end
                tstep_d = done_c ? T0 : T2;
            end
            T2: begin
                bus_c = regs_q[ry_c];
                g_d   = alu_c;
`ifdef PROC_STATUS_FLAGS_EN
                flags_d = {alu_c[DATA_W-1], (alu_c == '0)};
`endif
                tstep_d = T3;
            end
            T3: begin
                bus_c        = g_q;
                regs_d[rx_c] = bus_c;
                done_c       = 1'b1;
                tstep_d      = T0;
            end
            default: tstep_d = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            regs_q  <= '{default: '0};
`ifdef PROC_STATUS_FLAGS_EN
            flags_q <= 2'b00;
`endif
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            regs_q  <= regs_d;
`ifdef PROC_STATUS_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign Done     = done_c;
    assign BusWires = bus_c;
`ifdef PROC_STATUS_FLAGS_EN
    assign Flags    = flags_q;
`endif

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Bench for processador_multiciclo_param (DATA_W=16, NREGS=8): directed plan followed by random programs
// checked cycle by cycle against an instruction-level reference model.
module tb_processador_multiciclo_param;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        Done;
    logic [15:0] BusWires;
`ifdef PROC_STATUS_FLAGS_EN
    logic [1:0]  Flags;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_r [8];
    logic [1:0]  m_flags;

    processador_multiciclo_param #(.DATA_W(16), .NREGS(8)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .DIN      (DIN),
`ifdef PROC_STATUS_FLAGS_EN
        .Flags    (Flags),
`endif
        .Done     (Done),
        .BusWires (BusWires)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return a << b[3:0];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_flags = 2'b00;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs_q[i], m_r[i]);
`ifdef PROC_STATUS_FLAGS_EN
        chk({tag, "_flags"}, 16'(Flags), 16'(m_flags));
`endif
    endtask

    // Runs one instruction starting just after a falling edge with the core in T0.
    task automatic exec(input logic [15:0] instr, input logic [15:0] imm, input logic run_busy);
        logic [2:0]  op;
        logic [2:0]  x, y;
        logic [15:0] a, g;
        op = instr[15:13];
        x  = instr[12:10];
        y  = instr[9:7];
        Run = 1'b1;
        DIN = instr;
        #1;
        chk("t0_bus", BusWires, 16'h0);
        chk("t0_done", 16'(Done), 16'h0);
        @(negedge Clock);
        Run = run_busy;
        DIN = imm;
        #1;
        if (op == 3'd0) begin
            chk("mv_bus", BusWires, m_r[y]);
            chk("mv_done", 16'(Done), 16'h1);
            m_r[x] = m_r[y];
        end else if (op == 3'd1) begin
            chk("mvi_bus", BusWires, imm);
            chk("mvi_done", 16'(Done), 16'h1);
            m_r[x] = imm;
        end else if (op == 3'd7) begin
            chk("ill_bus", BusWires, 16'h0);
            chk("ill_done", 16'(Done), 16'h1);
        end else begin
            chk("alu_t1_bus", BusWires, m_r[x]);
            chk("alu_t1_done", 16'(Done), 16'h0);
            a = m_r[x];
            @(negedge Clock);
            DIN = 16'($urandom);
            #1;
            chk("alu_t2_bus", BusWires, m_r[y]);
            chk("alu_t2_done", 16'(Done), 16'h0);
            g = alu(op, a, m_r[y]);
            m_flags = {g[15], (g == 16'h0)};
            @(negedge Clock);
            #1;
            chk("alu_t3_bus", BusWires, g);
            chk("alu_t3_done", 16'(Done), 16'h1);
            m_r[x] = g;
        end
        @(negedge Clock);
        Run = 1'b0;
    endtask

    initial begin
        logic [15:0] instr;
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 16'h0;
        model_reset();
        repeat (2) @(negedge Clock);
        #1;
        chk("rst_bus", BusWires, 16'h0);
        chk("rst_done", 16'(Done), 16'h0);
        chk_regs("rst");
        Resetn = 1'b1;
        @(negedge Clock);

        // Directed plan
        exec(16'h2000, 16'h0005, 1'b0);
        chk("plan1_r0", dut.regs_q[0], 16'h0005);
        exec(16'h2400, 16'h0003, 1'b0);
        exec(16'h4080, 16'h0000, 1'b0);
        chk("plan2_add_r0", dut.regs_q[0], 16'h0008);
        exec(16'h6080, 16'h0000, 1'b0);
        chk("plan2_sub_r0", dut.regs_q[0], 16'h0005);
        exec(16'h2800, 16'hFFFF, 1'b0);
        exec(16'h2C00, 16'h0001, 1'b0);
        exec(16'h4980, 16'h0000, 1'b0);
        chk("plan3_r2", dut.regs_q[2], 16'h0000);
`ifdef PROC_STATUS_FLAGS_EN
        chk("plan3_flags", 16'(Flags), 16'h0001);
`endif
        exec(16'h3000, 16'h8000, 1'b0);
        exec(16'h3400, 16'h0001, 1'b0);
        exec(16'hB280, 16'h0000, 1'b0);
        chk("plan4_slt_r4", dut.regs_q[4], 16'h0001);
        exec(16'hD580, 16'h0000, 1'b0);
        chk("plan4_sll_r5", dut.regs_q[5], 16'h0002);
        exec(16'hE000, 16'h1234, 1'b1);
        chk_regs("plan5_ill");
        exec(16'h4480, 16'h0000, 1'b1);
        #1;
        chk("plan5_no_refetch_bus", BusWires, 16'h0);
        chk("plan5_no_refetch_done", 16'(Done), 16'h0);
        chk_regs("plan5");

        // Asynchronous reset in the middle of T2 of an add
        Run = 1'b1;
        DIN = 16'h4080;
        @(negedge Clock);
        Run = 1'b0;
        @(negedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        chk("plan6_bus", BusWires, 16'h0);
        chk("plan6_done", 16'(Done), 16'h0);
        model_reset();
        chk_regs("plan6");
        #1;
        Resetn = 1'b1;
        @(negedge Clock);
        exec(16'h2000, 16'h00A5, 1'b0);
        chk_regs("plan6_after");

        // Random programs, including X==Y, illegal ops and idle cycles
        for (int n = 0; n < 300; n++) begin
            instr = 16'($urandom);
            exec(instr, 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                DIN = 16'($urandom);
                #1;
                chk("idle_bus", BusWires, 16'h0);
                chk("idle_done", 16'(Done), 16'h0);
                @(negedge Clock);
            end
            if (n % 25 == 0) chk_regs("rand");
        end
        chk_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
